fc_vector_streamer: RTL and testbench

- Consumer for the fully connected layer's parallel output vector (data_out / valid_out).
- Captures each NUM_ELEMS-wide vector into a two-entry ping-pong buffer, then emits it one element per beat on a valid/ready stream to the downstream classifier or argmax stage.
- The producer has no backpressure, so any vector arriving while both buffers are full is dropped and counted.

---
 rtl/fc_vector_streamer.sv | 185 ++++++++++++++++++
 tb/tb_fc_vector_streamer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_vector_streamer.sv
// ---------------------------------------------------------------------------
// fc_vector_streamer
//
// Takes the fully connected layer's parallel output vector, parks it in one
// of two ping-pong buffers, and replays it one element per beat on a
// valid/ready stream for the downstream classifier / argmax stage. The
// producer cannot be stalled, so a vector that arrives while both buffers
// are occupied is dropped and counted.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   vec_in          NUM_ELEMS signed elements from the FC layer
//   vec_valid       one-cycle pulse marking a vector on vec_in
//   vec_ready       at least one buffer free (registered state only)
//   out_data        current signed element
//   out_index       position of out_data within its vector
//   out_last        final element of the vector
//   out_valid       stream element valid
//   out_ready       downstream accepts the element
//   busy            a buffer holds data or a vector is being streamed
//   overflow        sticky flag, set when a vector is dropped
//   drop_count      saturating count of dropped vectors
//   clear_overflow  synchronous clear of overflow and drop_count
// ---------------------------------------------------------------------------
module fc_vector_streamer #(
    parameter int NUM_ELEMS      = 1280,
    parameter int DATA_WIDTH     = 8,
    parameter int IDX_WIDTH      = $clog2(NUM_ELEMS),
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATA_WIDTH-1:0] vec_in [0:NUM_ELEMS-1],
    input  logic                        vec_valid,
    output logic                        vec_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]        out_index,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        overflow,
    output logic [DROP_CNT_WIDTH-1:0]   drop_count,
    input  logic                        clear_overflow
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ELEMS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                        state;
    logic [1:0]                    full;
    logic                          wr_sel;
    logic                          rd_sel;
    logic [IDX_WIDTH-1:0]          idx;
    logic signed [DATA_WIDTH-1:0]  bank [0:1][0:NUM_ELEMS-1];

    logic                          capture;
    logic                          drop;
    logic                          beat;
    logic                          last_beat;
    logic [IDX_WIDTH-1:0]          idx_inc;
    logic [1:0]                    full_set;
    logic [1:0]                    full_clr;

    // Readiness depends on registered occupancy only, so a buffer freed by a
    // last-beat transfer is offered to the producer one cycle later.
    assign vec_ready = ~rst & ~(full[0] & full[1]);
    assign capture   = vec_valid & vec_ready;
    assign drop      = vec_valid & ~vec_ready;
    assign beat      = out_valid & out_ready;
    assign last_beat = beat & (idx == LAST_IDX);
    assign idx_inc   = idx + IDX_WIDTH'(1);
    assign busy      = (|full) | (state == STREAM);

    // The write side always targets the free buffer, so a capture and a
    // last-beat release in the same cycle never touch the same full bit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        full_set = '0;
        full_clr = '0;
        if (capture) begin
            full_set[wr_sel] = 1'b1;
        end
        if (last_beat) begin
            full_clr[rd_sel] = 1'b1;
        end
    end

    // NOTE: the vector storage has no reset; occupancy is tracked by full,
    // so stale contents are never observed and resetting the array would
    // only add reset fan-out to every storage bit.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                bank[wr_sel][i] <= vec_in[i];
            end
        end
    end

    // Buffer bookkeeping, stream FSM and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            full      <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side sees the values from before this edge.
            full <= (full | full_set) & ~full_clr;
            if (capture) begin
                wr_sel <= ~wr_sel;
            end

            case (state)
                IDLE: begin
                    if (full[rd_sel]) begin
                        state     <= STREAM;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= bank[rd_sel][0];
                        out_index <= '0;
                        out_last  <= (LAST_IDX == '0);
                    end
                end

                STREAM: begin
                    if (last_beat) begin
                        rd_sel <= ~rd_sel;
                        idx    <= '0;
                        if (full[~rd_sel]) begin
                            // Back-to-back vector: element 0 follows with no bubble.
                            out_data  <= bank[~rd_sel][0];
                            out_index <= '0;
                            out_last  <= (LAST_IDX == '0);
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_index <= '0;
                            out_last  <= 1'b0;
                        end
                    end else if (beat) begin
                        idx       <= idx_inc;
                        out_data  <= bank[rd_sel][idx_inc];
                        out_index <= idx_inc;
                        out_last  <= (idx_inc == LAST_IDX);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Drop accounting. A drop coinciding with a clear leaves a count of one,
    // since that drop happened after everything the clear was meant to erase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_count <= DROP_CNT_WIDTH'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + DROP_CNT_WIDTH'(1);
            end
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_fc_vector_streamer.sv
// ---------------------------------------------------------------------------
// tb_fc_vector_streamer
//
// Directed bench for fc_vector_streamer with NUM_ELEMS=4, DATA_WIDTH=8 and
// DROP_CNT_WIDTH=2. Inputs are driven 1 ns after each rising edge and
// outputs are sampled at the same point, well clear of the active edge.
// ---------------------------------------------------------------------------
module tb_fc_vector_streamer;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IW  = 2;
    localparam int DCW = 2;

    logic                  clk;
    logic                  rst;
    logic signed [DW-1:0]  vec_in [0:N-1];
    logic                  vec_valid;
    logic                  vec_ready;
    logic signed [DW-1:0]  out_data;
    logic [IW-1:0]         out_index;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  overflow;
    logic [DCW-1:0]        drop_count;
    logic                  clear_overflow;

    int checks = 0;
    int errors = 0;

    fc_vector_streamer #(
        .NUM_ELEMS     (N),
        .DATA_WIDTH    (DW),
        .IDX_WIDTH     (IW),
        .DROP_CNT_WIDTH(DCW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vec_in        (vec_in),
        .vec_valid     (vec_valid),
        .vec_ready     (vec_ready),
        .out_data      (out_data),
        .out_index     (out_index),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .clear_overflow(clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a vector for exactly one edge.
    task automatic send_vec(input int a, input int b, input int c, input int d);
        vec_in[0] = DW'(a);
        vec_in[1] = DW'(b);
        vec_in[2] = DW'(c);
        vec_in[3] = DW'(d);
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
    endtask

    task automatic check_beat(input string tag, input int index, input int data,
                              input logic last);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_index"}, 32'(out_index), index);
        check({tag, "_data"},  out_data, data);
        check({tag, "_last"},  32'(out_last), 32'(last));
    endtask

    initial begin
        int exp_a [0:N-1];
        int exp_ab [0:2*N-1];
        int stall [0:6];
        int n;

        exp_a  = '{10, -20, 127, -128};
        exp_ab = '{1, 2, 3, 4, 5, 6, 7, 8};
        stall  = '{1, 0, 0, 1, 0, 1, 1};

        rst            = 1'b1;
        vec_valid      = 1'b0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        for (int i = 0; i < N; i++) vec_in[i] = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_vec_ready",  32'(vec_ready), 0);
        check("rst_out_valid",  32'(out_valid), 0);
        check("rst_out_data",   out_data, 0);
        check("rst_out_index",  32'(out_index), 0);
        check("rst_busy",       32'(busy), 0);
        check("rst_overflow",   32'(overflow), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        rst = 1'b0;
        tick();
        check("post_rst_vec_ready", 32'(vec_ready), 1);

        // ---------------- single vector, latency two edges ----------------
        out_ready = 1'b1;
        send_vec(10, -20, 127, -128);
        check("t1_latency_valid", 32'(out_valid), 0);
        check("t1_busy_captured", 32'(busy), 1);
        tick();
        for (int i = 0; i < N; i++) begin
            check_beat("t1_beat", i, exp_a[i], i == N - 1);
            tick();
        end
        check("t1_done_valid", 32'(out_valid), 0);
        tick();
        check("t1_done_busy", 32'(busy), 0);

        // ---------------- same vector with stalls ----------------
        out_ready = 1'b0;
        send_vec(10, -20, 127, -128);
        tick();
        n = 0;
        for (int p = 0; p < 7; p++) begin
            out_ready = stall[p][0];
            check_beat("t2_stall", n, exp_a[n], n == N - 1);
            tick();
            if (stall[p] != 0) n++;
        end
        check("t2_transfers", n, N);
        check("t2_done_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        tick();

        // ---------------- A then B back to back, no bubble ----------------
        send_vec(1, 2, 3, 4);
        send_vec(5, 6, 7, 8);
        for (int j = 0; j < 2 * N; j++) begin
            check_beat("t3_ab", j % N, exp_ab[j], (j % N) == N - 1);
            tick();
        end
        check("t3_done_valid", 32'(out_valid), 0);
        tick();

        // ---------------- A, B, C with no drain: C dropped ----------------
        out_ready = 1'b0;
        send_vec(1, 2, 3, 4);
        check("t4_ready_after_a", 32'(vec_ready), 1);
        send_vec(5, 6, 7, 8);
        check("t4_ready_after_b", 32'(vec_ready), 0);
        send_vec(9, 9, 9, 9);
        check("t4_overflow",   32'(overflow), 1);
        check("t4_drop_count", 32'(drop_count), 1);
        check("t4_hold_data",  out_data, 1);
        out_ready = 1'b1;
        for (int j = 0; j < 2 * N; j++) begin
            check_beat("t4_ab", j % N, exp_ab[j], (j % N) == N - 1);
            tick();
        end
        check("t4_done_valid", 32'(out_valid), 0);
        tick();
        check("t4_ready_again", 32'(vec_ready), 1);
        check("t4_busy_idle",   32'(busy), 0);

        // ---------------- saturation and clear/drop collision ----------------
        out_ready = 1'b0;
        send_vec(1, 2, 3, 4);
        send_vec(5, 6, 7, 8);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("t5_cleared_overflow", 32'(overflow), 0);
        check("t5_cleared_count",    32'(drop_count), 0);
        for (int i = 0; i < 5; i++) begin
            send_vec(9, 9, 9, 9);
            check("t5_sat_count", 32'(drop_count), (i + 1 > 3) ? 3 : i + 1);
        end
        check("t5_sat_overflow", 32'(overflow), 1);
        clear_overflow = 1'b1;
        send_vec(9, 9, 9, 9);
        clear_overflow = 1'b0;
        check("t5_collide_overflow", 32'(overflow), 1);
        check("t5_collide_count",    32'(drop_count), 1);

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_beat("t6_pre_rst", 1, 2, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_rst_valid",      32'(out_valid), 0);
        check("t6_rst_data",       out_data, 0);
        check("t6_rst_index",      32'(out_index), 0);
        check("t6_rst_last",       32'(out_last), 0);
        check("t6_rst_busy",       32'(busy), 0);
        check("t6_rst_vec_ready",  32'(vec_ready), 0);
        check("t6_rst_overflow",   32'(overflow), 0);
        check("t6_rst_drop_count", 32'(drop_count), 0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_vec_ready", 32'(vec_ready), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t6_no_stale", 32'(out_valid), 0);
            tick();
        end
        send_vec(-1, 0, 64, -64);
        tick();
        check_beat("t6_d0", 0, -1, 1'b0);
        tick();
        check_beat("t6_d1", 1, 0, 1'b0);
        tick();
        check_beat("t6_d2", 2, 64, 1'b0);
        tick();
        check_beat("t6_d3", 3, -64, 1'b1);
        tick();
        check("t6_done_valid", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
